// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flush and multdiv hold for the 5-stage core.
// Optional stall/flush statistics counters are enabled by defining PIPE_HAZARD_CTRL_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MD_LIMIT = 40
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic        fd_uses_rs,
  input  logic        fd_uses_rt,
  input  logic [4:0]  dx_rd,
  input  logic        dx_is_load,
  input  logic        dx_is_md,
  input  logic        x_taken,
  input  logic        md_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        fd_clr,
  output logic        dx_clr,
  output logic        xm_clr,
  output logic        md_start,
  output logic        stall,
`ifdef PIPE_HAZARD_CTRL_STALL_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic        md_timeout
);

  localparam int CW = $clog2(MD_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_LIMIT - 1);

  typedef enum logic {RUN, MD_BUSY} stateT;

  stateT         stateReg, stateNext;
  logic [CW-1:0] mdCntReg, mdCntNext;
  logic          timeoutSet;
  logic          loadUse;

  assign loadUse = dx_is_load && (dx_rd != 5'd0) &&
                   ((fd_uses_rs && (fd_rs == dx_rd)) || (fd_uses_rt && (fd_rt == dx_rd)));

  always_ff @(posedge clk) begin
    if (clr) begin
      stateReg   <= RUN;
      mdCntReg   <= '0;
      md_timeout <= 1'b0;
    end else begin
      stateReg <= stateNext;
      mdCntReg <= mdCntNext;
      if (timeoutSet) md_timeout <= 1'b1;
    end
  end

  always_comb begin
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    dx_en      = 1'b1;
    xm_en      = 1'b1;
    fd_clr     = 1'b0;
    dx_clr     = 1'b0;
    xm_clr     = 1'b0;
    md_start   = 1'b0;
    stateNext  = stateReg;
    mdCntNext  = mdCntReg;
    timeoutSet = 1'b0;
    if (clr) begin
      fd_clr = 1'b1;
      dx_clr = 1'b1;
      xm_clr = 1'b1;
    end else begin
      case (stateReg)
        RUN: begin
          if (x_taken) begin
            fd_clr = 1'b1;
            dx_clr = 1'b1;
          end else if (dx_is_md) begin
            md_start  = 1'b1;
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_clr    = 1'b1;
            stateNext = MD_BUSY;
            mdCntNext = '0;
          end else if (loadUse) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_clr = 1'b1;
          end
        end
        MD_BUSY: begin
          // Release on a valid result, or force it once the budget is spent.
          if (md_ready) begin
            stateNext = RUN;
          end else if (mdCntReg >= CNT_LAST) begin
            stateNext  = RUN;
            timeoutSet = 1'b1;
          end else begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_clr    = 1'b1;
            mdCntNext = mdCntReg + 1'b1;
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end

  assign stall = ~pc_en & ~clr;

`ifdef PIPE_HAZARD_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if ((stateReg == RUN) && x_taken && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic clr, fd_uses_rs, fd_uses_rt, dx_is_load, dx_is_md, x_taken, md_ready;
  logic [4:0] fd_rs, fd_rt, dx_rd;
  logic pc_en, fd_en, dx_en, xm_en, fd_clr, dx_clr, xm_clr, md_start, stall, md_timeout;
`ifdef PIPE_HAZARD_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [31:0] stallCount;
  logic [15:0] flushCount;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;

  // Model: mdAge counts cycles elapsed since md_start while the md instruction waits.
  bit mdWaiting;
  int mdAge;
  bit tmoSticky;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LIMIT(LIM)) dut (
    .clk(clk), .clr(clr), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .dx_rd(dx_rd),
    .dx_is_load(dx_is_load), .dx_is_md(dx_is_md), .x_taken(x_taken),
    .md_ready(md_ready), .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en),
    .xm_en(xm_en), .fd_clr(fd_clr), .dx_clr(dx_clr), .xm_clr(xm_clr),
    .md_start(md_start), .stall(stall),
`ifdef PIPE_HAZARD_CTRL_STALL_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .md_timeout(md_timeout)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic setIn(input bit c, input bit xt, input bit md, input bit ld, input int rd,
                       input int rs, input bit urs, input int rt, input bit urt, input bit rdy);
    clr = c; x_taken = xt; dx_is_md = md; dx_is_load = ld; dx_rd = 5'(rd);
    fd_rs = 5'(rs); fd_uses_rs = urs; fd_rt = 5'(rt); fd_uses_rt = urt; md_ready = rdy;
  endtask

  // Inputs are applied after a falling edge; outputs are checked 1ns later, model advances at the rising edge.
  task automatic runCycle();
    bit hazard, holdMd;
    bit ePc, eFd, eDx, eXm, eFc, eDc, eXc, eMs, eSt;
    #1;
    hazard = dx_is_load && dx_rd != 0 &&
             ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
    {ePc, eFd, eDx, eXm} = 4'b1111;
    {eFc, eDc, eXc, eMs} = 4'b0000;
    if (clr) begin
      {eFc, eDc, eXc} = 3'b111;
    end else if (mdWaiting) begin
      holdMd = !md_ready && (mdAge < LIM);
      if (holdMd) begin
        {ePc, eFd, eDx} = 3'b000;
        eXc = 1'b1;
      end
    end else if (x_taken) begin
      {eFc, eDc} = 2'b11;
    end else if (dx_is_md) begin
      eMs = 1'b1;
      {ePc, eFd, eDx} = 3'b000;
      eXc = 1'b1;
    end else if (hazard) begin
      {ePc, eFd} = 2'b00;
      eDc = 1'b1;
    end
    eSt = !ePc && !clr;
    checkEq("ctrl_outs", 32'({pc_en, fd_en, dx_en, xm_en, fd_clr, dx_clr, xm_clr, md_start, stall}),
            32'({ePc, eFd, eDx, eXm, eFc, eDc, eXc, eMs, eSt}));
    checkEq("md_timeout", 32'(md_timeout), 32'(tmoSticky));
`ifdef PIPE_HAZARD_CTRL_STALL_CNT_EN
    checkEq("stall_cnt", stall_cnt, stallCount);
    checkEq("flush_cnt", 32'(flush_cnt), 32'(flushCount));
`endif
    $display("cyc %0d clr=%b xt=%b md=%b ld=%b rdy=%b wait=%b -> pc=%b fd=%b dx=%b xm=%b clr=%b%b%b start=%b stall=%b tmo=%b",
             cyc, clr, x_taken, dx_is_md, hazard, md_ready, mdWaiting, pc_en, fd_en, dx_en, xm_en,
             fd_clr, dx_clr, xm_clr, md_start, stall, md_timeout);
    @(posedge clk);
`ifdef PIPE_HAZARD_CTRL_STALL_CNT_EN
    if (clr) begin
      stallCount = 0;
      flushCount = 0;
    end else begin
      if (eSt) stallCount = stallCount + 1;
      if (!mdWaiting && x_taken && flushCount != 16'hFFFF) flushCount = flushCount + 1;
    end
`endif
    if (clr) begin
      mdWaiting = 0; mdAge = 0; tmoSticky = 0;
    end else if (mdWaiting) begin
      if (md_ready) mdWaiting = 0;
      else if (mdAge >= LIM) begin
        mdWaiting = 0; tmoSticky = 1;
      end else mdAge++;
    end else if (!x_taken && dx_is_md) begin
      mdWaiting = 1; mdAge = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    mdWaiting = 0; mdAge = 0; tmoSticky = 0;
`ifdef PIPE_HAZARD_CTRL_STALL_CNT_EN
    stallCount = 0; flushCount = 0;
`endif
    setIn(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    // Reset held two cycles with a pending md instruction.
    runCycle();
    runCycle();
    checkEq("rst_mdstart", 32'(md_start), 32'd0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();
    // Load-use match, then the same with dx_rd = 0.
    setIn(0, 0, 0, 1, 5, 5, 1, 0, 0, 0); runCycle();
    setIn(0, 0, 0, 1, 0, 0, 1, 0, 0, 0); runCycle();
    // Flush wins over a simultaneous load-use.
    setIn(0, 1, 0, 1, 5, 5, 1, 0, 0, 0); runCycle();
    // Multdiv with md_ready three cycles after md_start.
    setIn(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); runCycle();
    runCycle();
    runCycle();
    setIn(0, 0, 1, 0, 0, 0, 0, 0, 0, 1); runCycle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();
    // Timeout: md_ready never arrives.
    setIn(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < LIM + 1; i++) runCycle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();
    runCycle();
    checkEq("tmo_sticky", 32'(md_timeout), 32'd1);
    // Reset aborts an md wait.
    setIn(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); runCycle();
    runCycle();
    setIn(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); runCycle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();
    // Randomized traffic with a small register pool to provoke matches.
    for (int i = 0; i < 800; i++) begin
      setIn($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3) == 0);
      runCycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
